mem_loader: RTL and testbench

Unified 256 x 15-bit instruction/data memory with a byte-stream boot loader, sitting directly on the processor's memory bus (Adr, MemWrite, MemData1[14:8], MemData2[7:0]). After reset it clears the array, accepts a program image as a stream of byte pairs, then releases the processor from reset and serves its fetches, loads and stores. The `MemData2` tristate is resolved at the top level using `rdata_lo_oe`.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_loader.sv | 148 ++++++++++++++
 tb/tb_mem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the unified instruction/data memory
// and its byte-stream boot loader.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int HI_W   = 7;
  localparam int LO_W   = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Storage array: one synchronous write port and one asynchronous read port.
// No reset; the loader clears the contents after every reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rd
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/mem_loader.sv
// Unified 256 x 15-bit memory with boot loader: clears the array, loads a
// byte-pair image, then releases the processor and serves its bus.
module mem_loader #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int HI_W   = mem_pkg::HI_W,
  parameter int LO_W   = mem_pkg::LO_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_error,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic              mem_write,
  input  logic [LO_W-1:0]   wdata,
  output logic [HI_W-1:0]   rdata_hi,
  output logic [LO_W-1:0]   rdata_lo,
  output logic              rdata_lo_oe
);

  import mem_pkg::*;

  localparam int WIDTH = HI_W + LO_W;

  mem_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic [HI_W-1:0]   hi_reg;

  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd;

  assign accept = load_valid && load_ready;

  // Write source mux: clear sweep, loader word, or processor store.
  always_comb begin
    we = 1'b0;
    wa = cnt;
    wd = '0;
    if (reset) begin
      case (state)
        CLEAR: begin
          we = 1'b1;
        end
        LOAD_LO: begin
          we = accept;
          wd = {hi_reg, load_data[LO_W-1:0]};
        end
        RUN: begin
          we = mem_write;
          wa = adr;
          wd = {{HI_W{1'b0}}, wdata};
        end
        default: begin
          we = 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .WIDTH (WIDTH)
  ) u_array (
    .clk(clk),
    .we (we),
    .wa (wa),
    .wd (wd),
    .ra (adr),
    .rd (rd)
  );

  assign rdata_hi    = rd[LO_W +: HI_W];
  assign rdata_lo    = rd[LO_W-1:0];
  assign rdata_lo_oe = (state == RUN) && !mem_write;

  // cnt doubles as clear pointer and load address; it wraps to 0 when the
  // clear sweep ends, which is exactly where loading starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      hi_reg     <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      cpu_reset <= (state != RUN);
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == '1) begin
            state      <= LOAD_HI;
            load_ready <= 1'b1;
          end
        end
        LOAD_HI: begin
          if (accept) begin
            if (load_data[7] || load_last) begin
              state      <= ERROR;
              load_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              hi_reg <= load_data[HI_W-1:0];
              state  <= LOAD_LO;
            end
          end
        end
        LOAD_LO: begin
          if (accept) begin
            cnt <= cnt + ADDR_W'(1);
            if (load_last || (cnt == '1)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state <= LOAD_HI;
            end
          end
        end
        RUN: begin
          load_ready <= 1'b0;
          load_done  <= 1'b1;
        end
        ERROR: begin
          load_ready <= 1'b0;
          load_error <= 1'b1;
        end
        default: begin
          state      <= CLEAR;
          cnt        <= '0;
          load_ready <= 1'b0;
          load_done  <= 1'b0;
          load_error <= 1'b0;
          cpu_reset  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a per-cycle behavioural model plus
// directed load, store, error, truncation and reset scenarios.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready, load_done, load_error, cpu_reset;
  logic [7:0] adr = 8'h00;
  logic       mem_write = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [6:0] rdata_hi;
  logic [7:0] rdata_lo;
  logic       rdata_lo_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_error (load_error),
    .cpu_reset  (cpu_reset),
    .adr        (adr),
    .mem_write  (mem_write),
    .wdata      (wdata),
    .rdata_hi   (rdata_hi),
    .rdata_lo   (rdata_lo),
    .rdata_lo_oe(rdata_lo_oe)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: clearing countdown, pending hi byte, load address,
  // and a plain array image of memory.
  bit          live = 1'b0;
  int          clear_left = 0;
  int          load_addr = 0;
  int          run_age = 0;
  bit          in_run = 1'b0;
  bit          in_err = 1'b0;
  bit          have_hi = 1'b0;
  logic [6:0]  pend_hi = 7'h00;
  logic [14:0] model_mem [256];

  always @(posedge clk) begin
    if (!reset) begin
      live       = 1'b1;
      clear_left = 256;
      in_run     = 1'b0;
      in_err     = 1'b0;
      have_hi    = 1'b0;
      load_addr  = 0;
      run_age    = 0;
    end else if (live) begin
      if (clear_left > 0) begin
        model_mem[256 - clear_left] = 15'h0000;
        clear_left--;
      end else if (in_run) begin
        if (run_age < 3) run_age++;
        if (mem_write) model_mem[adr] = {7'h00, wdata};
      end else if (!in_err && load_valid) begin
        if (!have_hi) begin
          if (load_data[7] || load_last) in_err = 1'b1;
          else begin
            pend_hi = load_data[6:0];
            have_hi = 1'b1;
          end
        end else begin
          model_mem[load_addr] = {pend_hi, load_data};
          have_hi = 1'b0;
          if (load_last || load_addr == 255) in_run = 1'b1;
          load_addr++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checkOutput("load_ready", {15'h0, load_ready}, {15'h0, (clear_left == 0) && !in_run && !in_err});
      checkOutput("load_done", {15'h0, load_done}, {15'h0, in_run});
      checkOutput("load_error", {15'h0, load_error}, {15'h0, in_err});
      checkOutput("cpu_reset", {15'h0, cpu_reset}, {15'h0, !(in_run && run_age >= 1)});
      checkOutput("rdata_lo_oe", {15'h0, rdata_lo_oe}, {15'h0, in_run && !mem_write});
      if (clear_left == 0)
        checkOutput("rdata", {1'b0, rdata_hi, rdata_lo}, {1'b0, model_mem[adr]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic waitClear(output int n);
    n = 0;
    while (!load_ready && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic readWord(input logic [7:0] a, input string name, input logic [15:0] exp);
    adr = a;
    #2;
    checkOutput(name, {1'b0, rdata_hi, rdata_lo}, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    logic [14:0] all_or;

    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    checkOutput("reset_cpu_reset", {15'h0, cpu_reset}, 16'h1);
    checkOutput("reset_ready", {15'h0, load_ready}, 16'h0);
    waitClear(n);
    checkOutput("clear_cycles", n[15:0], 16'd256);
    all_or = '0;
    for (int a = 0; a < 256; a++) begin
      adr = a[7:0];
      #2;
      all_or = all_or | {rdata_hi, rdata_lo};
      step();
    end
    checkOutput("cleared_all_zero", {1'b0, all_or}, 16'h0);
    checkOutput("idle_cpu_reset", {15'h0, cpu_reset}, 16'h1);

    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h7F, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h55, 1'b1);
    checkOutput("load3_done", {15'h0, load_done}, 16'h1);
    checkOutput("load3_cpu_reset_hold", {15'h0, cpu_reset}, 16'h1);
    step();
    checkOutput("load3_cpu_reset_rel", {15'h0, cpu_reset}, 16'h0);
    readWord(8'd0, "word0", 16'h1234);
    readWord(8'd1, "word1", 16'h7F01);
    readWord(8'd2, "word2", 16'h0055);
    readWord(8'd3, "word3", 16'h0000);

    adr = 8'h40;
    wdata = 8'hA5;
    mem_write = 1'b1;
    #2;
    checkOutput("store_oe", {15'h0, rdata_lo_oe}, 16'h0);
    checkOutput("store_old", {1'b0, rdata_hi, rdata_lo}, 16'h0000);
    step();
    mem_write = 1'b0;
    #2;
    checkOutput("store_new", {1'b0, rdata_hi, rdata_lo}, 16'h00A5);
    checkOutput("store_oe_after", {15'h0, rdata_lo_oe}, 16'h1);
    step();

    doReset();
    waitClear(n);
    applyStimulus(8'h80, 1'b0);
    checkOutput("err80_error", {15'h0, load_error}, 16'h1);
    checkOutput("err80_ready", {15'h0, load_ready}, 16'h0);
    repeat (50) step();
    checkOutput("err80_cpu_reset", {15'h0, cpu_reset}, 16'h1);
    applyStimulus(8'h12, 1'b0);
    checkOutput("err80_sticky", {15'h0, load_error}, 16'h1);

    doReset();
    checkOutput("err_cleared", {15'h0, load_error}, 16'h0);
    waitClear(n);
    applyStimulus(8'h12, 1'b1);
    checkOutput("errlast_error", {15'h0, load_error}, 16'h1);

    doReset();
    waitClear(n);
    for (int p = 0; p < 256; p++) begin
      applyStimulus(8'(p & 8'h7F), 1'b0);
      applyStimulus(8'((p * 3) & 8'hFF), 1'b0);
    end
    checkOutput("trunc_done", {15'h0, load_done}, 16'h1);
    checkOutput("trunc_error", {15'h0, load_error}, 16'h0);
    applyStimulus(8'h11, 1'b0);
    readWord(8'd255, "trunc_last", 16'h7FFD);
    readWord(8'd1, "trunc_word1", 16'h0103);

    checkOutput("run_cpu_reset", {15'h0, cpu_reset}, 16'h0);
    reset = 1'b0;
    step();
    checkOutput("midrun_cpu_reset", {15'h0, cpu_reset}, 16'h1);
    checkOutput("midrun_done", {15'h0, load_done}, 16'h0);
    reset = 1'b1;
    waitClear(n);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h05, 1'b0);
    applyStimulus(8'h06, 1'b0);
    doReset();
    waitClear(n);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b1);
    step();
    readWord(8'd0, "reload_word0", 16'h0001);
    readWord(8'd1, "reload_word1", 16'h0000);
    readWord(8'd2, "reload_word2", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
